funct_generator_nco: RTL and testbench

Phase-accumulator sequencer that sits directly upstream of the function-generator waveform LUT. It advances a phase accumulator by a programmable frequency word, drives the LUT read address, and captures the LUT sample one cycle later. It then scales the sample by an amplitude word and pushes the result into the downstream sample FIFO with a push/full handshake.

---
 rtl/funct_generator_nco.sv | 125 ++++++++++++
 tb/tb_funct_generator_nco.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/funct_generator_nco.sv
// Phase-accumulator NCO sequencer: steps the LUT address, scales the returned
// sample by an unsigned amplitude and hands it to the sample FIFO.
module funct_generator_nco #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int PHASE_WIDTH = 24,
  parameter int AMP_WIDTH   = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [PHASE_WIDTH-1:0] freq_word_i,
  input  logic [AMP_WIDTH-1:0]   amp_i,
  output logic [ADDR_WIDTH-1:0]  read_addr_o,
  input  logic [DATA_WIDTH-1:0]  read_data_i,
  input  logic                   fifo_full_i,
  output logic                   fifo_push_o,
  output logic [DATA_WIDTH-1:0]  fifo_data_o,
  output logic                   busy_o,
  output logic [CNT_WIDTH-1:0]   sample_cnt_o
);

  localparam int PROD_WIDTH = DATA_WIDTH + AMP_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, PUSH} state_t;

  state_t                   state_q, state_d;
  logic [PHASE_WIDTH-1:0]   phase_q, phase_d;
  logic [PHASE_WIDTH-1:0]   freq_q, freq_d;
  logic [AMP_WIDTH-1:0]     amp_q, amp_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     push_ok;
  logic signed [PROD_WIDTH-1:0] sample_ext, amp_ext, product;
  logic [DATA_WIDTH-1:0]    scaled;

  // Amplitude is zero-extended so the gain stays positive and below one.
  assign sample_ext = {{(AMP_WIDTH+1){read_data_i[DATA_WIDTH-1]}}, read_data_i};
  assign amp_ext    = {{(DATA_WIDTH+1){1'b0}}, amp_q};
  assign product    = sample_ext * amp_ext;
  assign scaled     = DATA_WIDTH'(product >>> AMP_WIDTH);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (en_i) state_d = ADDR;
        ADDR:    state_d = DATA;
        DATA:    state_d = PUSH;
        PUSH:    if (!fifo_full_i) state_d = en_i ? ADDR : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    push_ok = (state_q == PUSH) && !fifo_full_i && !clr_i;
    busy_o  = (state_q != IDLE);
  end

  assign fifo_push_o  = push_ok;
  assign read_addr_o  = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign fifo_data_o  = data_q;
  assign sample_cnt_o = cnt_q;

  always_comb begin
    phase_d = phase_q;
    freq_d  = freq_q;
    amp_d   = amp_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if (clr_i) begin
      phase_d = '0;
      cnt_d   = '0;
      data_d  = '0;
    end else begin
      if ((state_q == IDLE) && en_i) begin
        freq_d = freq_word_i;
        amp_d  = amp_i;
      end
      if (state_q == DATA) begin
        data_d = scaled;
      end
      // Accepted push advances phase and re-latches the controls for the next sample
      if (push_ok) begin
        phase_d = phase_q + freq_q;
        cnt_d   = cnt_q + 1'b1;
        freq_d  = freq_word_i;
        amp_d   = amp_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      freq_q  <= '0;
      amp_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      phase_q <= phase_d;
      freq_q  <= freq_d;
      amp_q   <= amp_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_funct_generator_nco.sv
// Scoreboard bench for funct_generator_nco: a registered LUT model feeds the DUT,
// expected (address, sample) pairs are queued per run and checked on each push.
module tb_funct_generator_nco;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i = 1'b0;
  logic        clr_i = 1'b0;
  logic [23:0] freq_word_i = '0;
  logic [7:0]  amp_i = '0;
  logic [7:0]  read_addr_o;
  logic [31:0] lut_q = '0;
  logic        fifo_full_i = 1'b0;
  logic        fifo_push_o;
  logic [31:0] fifo_data_o;
  logic        busy_o;
  logic [15:0] sample_cnt_o;

  funct_generator_nco dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .freq_word_i  (freq_word_i),
    .amp_i        (amp_i),
    .read_addr_o  (read_addr_o),
    .read_data_i  (lut_q),
    .fifo_full_i  (fifo_full_i),
    .fifo_push_o  (fifo_push_o),
    .fifo_data_o  (fifo_data_o),
    .busy_o       (busy_o),
    .sample_cnt_o (sample_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int          checks = 0;
  int          failures = 0;
  int          pushes_seen = 0;
  int          cyc = 0;
  int          last_push_cyc = -1;
  bit          check_period = 1'b0;
  logic [15:0] exp_cnt = '0;
  logic [23:0] ph = '0;
  bit          lut_mode = 1'b0;
  logic [31:0] lut_const = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lut_fn(input logic [7:0] a);
    if (lut_mode == 1'b0) return lut_const;
    return {a, ~a, a ^ 8'hA5, 8'h3C};
  endfunction

  function automatic logic [31:0] scale(input logic [31:0] s, input logic [7:0] a);
    longint sv, av, p;
    sv = longint'($signed(s));
    av = longint'(a);
    p  = (sv * av) >>> 8;
    return p[31:0];
  endfunction

  // LUT with exactly one cycle of read latency
  always @(posedge clk) lut_q <= lut_fn(read_addr_o);
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    sb_entry_t e;
    if (rst_n === 1'b1 && fifo_push_o === 1'b1) begin
      pushes_seen <= pushes_seen + 1;
      if (fifo_full_i) check("push_while_full", fifo_push_o, 1'b0);
      if (sb.size() == 0) begin
        check("unexpected_push", fifo_push_o, 1'b0);
      end else begin
        e = sb.pop_front();
        $display("push addr=%0d data=%08h cnt=%0d (exp addr=%0d data=%08h)",
                 read_addr_o, fifo_data_o, sample_cnt_o, e.addr, e.data);
        check("push_addr", read_addr_o, e.addr);
        check("push_data", fifo_data_o, e.data);
        check("push_cnt", sample_cnt_o, exp_cnt);
      end
      if (check_period && last_push_cyc >= 0) check("push_period", cyc - last_push_cyc, 3);
      last_push_cyc <= cyc;
      exp_cnt <= exp_cnt + 1'b1;
    end
  end

  // Queue n expected samples, run them, and stop (en_i dropped in ADDR or DATA of the last)
  task automatic run_n(input int n, input int dly, input bit per);
    int target;
    int t;
    for (int i = 0; i < n; i++) begin
      sb_entry_t e;
      e.addr = ph[23:16];
      e.data = scale(lut_fn(ph[23:16]), amp_i);
      sb.push_back(e);
      ph = ph + freq_word_i;
    end
    target = pushes_seen + n - 1;
    check_period = per;
    last_push_cyc = -1;
    en_i = 1'b1;
    t = 0;
    while (pushes_seen < target && t < 500) begin
      @(negedge clk); #1; t++;
    end
    check("run_progress", pushes_seen, target);
    @(posedge clk);
    repeat (dly) @(posedge clk);
    #1 en_i = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk); #1; t++;
    end
    check("sb_drain", sb.size(), 0);
    @(posedge clk); #1;
    check("idle_busy", busy_o, 1'b0);
    check("idle_addr_retained", read_addr_o, ph[23:16]);
    check_period = 1'b0;
  endtask

  task automatic do_clr();
    @(posedge clk); #1 clr_i = 1'b1;
    @(posedge clk); #1 clr_i = 1'b0;
    ph = '0;
    exp_cnt = '0;
    check("clr_busy", busy_o, 1'b0);
    check("clr_cnt", sample_cnt_o, 16'd0);
    check("clr_addr", read_addr_o, 8'd0);
    check("clr_data", fifo_data_o, 32'd0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    #1;
    check("rst_addr", read_addr_o, 8'd0);
    check("rst_push", fifo_push_o, 1'b0);
    check("rst_data", fifo_data_o, 32'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_cnt", sample_cnt_o, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic sweep
    lut_mode = 1'b0; lut_const = 32'h4000_0000;
    freq_word_i = 24'h010000; amp_i = 8'h80;
    run_n(4, 0, 1'b1);
    check("sweep_cnt", sample_cnt_o, 16'd4);

    // Negative scaling, en_i dropped during DATA; continues from retained phase
    lut_const = 32'h8000_0000;
    run_n(2, 1, 1'b0);
    amp_i = 8'h00;
    run_n(2, 1, 1'b0);

    // Wrap-around with an address-dependent LUT
    do_clr();
    lut_mode = 1'b1; amp_i = 8'hC3; freq_word_i = 24'h800000;
    run_n(4, 0, 1'b1);
    do_clr();
    freq_word_i = 24'hFFFFFF;
    run_n(4, 0, 1'b1);

    // Backpressure: five full cycles in PUSH, then exactly one push
    freq_word_i = 24'h010000; amp_i = 8'h80;
    fifo_full_i = 1'b1;
    begin
      sb_entry_t e;
      e.addr = ph[23:16];
      e.data = scale(lut_fn(ph[23:16]), amp_i);
      sb.push_back(e);
      ph = ph + freq_word_i;
    end
    en_i = 1'b1;
    @(posedge clk); #1 en_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_push", fifo_push_o, 1'b0);
      check("stall_data", fifo_data_o, sb[0].data);
      check("stall_addr", read_addr_o, sb[0].addr);
    end
    @(posedge clk); #1 fifo_full_i = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    check("bp_drain", sb.size(), 0);
    @(posedge clk); #1;
    check("bp_cnt", sample_cnt_o, exp_cnt);
    check("bp_addr", read_addr_o, ph[23:16]);
    check("bp_busy", busy_o, 1'b0);

    // Clear while in PUSH: no push, everything zeroed
    fifo_full_i = 1'b1;
    en_i = 1'b1;
    @(posedge clk); #1 en_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    fifo_full_i = 1'b0;
    clr_i = 1'b1;
    #3 check("clr_push_blocked", fifo_push_o, 1'b0);
    @(posedge clk); #1 clr_i = 1'b0;
    ph = '0;
    exp_cnt = '0;
    check("clrpush_busy", busy_o, 1'b0);
    check("clrpush_cnt", sample_cnt_o, 16'd0);
    check("clrpush_addr", read_addr_o, 8'd0);
    check("clrpush_data", fifo_data_o, 32'd0);
    repeat (3) @(posedge clk); #1;

    // Async reset during DATA
    freq_word_i = 24'h030000; amp_i = 8'h40;
    run_n(2, 0, 1'b0);
    en_i = 1'b1;
    @(posedge clk); #1 en_i = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_busy", busy_o, 1'b1);
    check("pre_rst_addr", read_addr_o, ph[23:16]);
    rst_n = 1'b0;
    #1;
    check("arst_addr", read_addr_o, 8'd0);
    check("arst_push", fifo_push_o, 1'b0);
    check("arst_data", fifo_data_o, 32'd0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_cnt", sample_cnt_o, 16'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    ph = '0;
    exp_cnt = '0;
    repeat (3) @(posedge clk); #1;
    run_n(1, 0, 1'b0);
    check("post_rst_cnt", sample_cnt_o, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
